// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial_tx frame transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Baud counter: tick is high on the last cycle of every CLKS_PER_BIT-cycle bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: idle-high, start bit, DATA_W bits LSB-first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    import serial_tx_pkg::*;

    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              tick;
    logic              timer_clear;

    // Holding the timer clear through IDLE makes START last exactly CLKS_PER_BIT cycles.
    assign timer_clear = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = in_data;
                    bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d     = ^in_data;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx leaves a flop aligned with the state.
    always_comb begin
        tx_d = LINE_IDLE;
        case (state_d)
            START:  tx_d = LINE_START;
            DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: tx_d = par_d;
`endif
            STOP:   tx_d = LINE_STOP;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == STOP) && tick;

endmodule
